// File: rtl/dcache_responder.sv
// dcache_responder
// ----------------
// Direct-mapped, write-back, write-allocate data cache that answers the core's
// single-word load/store port. Hits complete with no wait states. Misses
// write back a dirty victim first if needed. They then fill the whole 256-bit
// line from physical memory and retry the still-held request from IDLE.
//
// Handshake semantics (both sides):
//   A requester raises mem_d_read or mem_d_write and holds it, together with
//   address, data and byte enables, until it sees a one-cycle mem_d_resp.
//   The cache raises pmem_read or pmem_write and holds it, together with
//   pmem_address and pmem_wdata, until it sees a one-cycle pmem_resp.
//   A request that is withdrawn mid-miss gets no response. The miss still
//   finishes and installs the line.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   mem_d_read/write    CPU load/store request (mutually exclusive)
//   mem_d_address       word address (bits [1:0] zero)
//   mem_d_wdata         lane-aligned store data
//   mem_d_byte_enable   store byte lanes
//   mem_d_resp          one-cycle completion pulse
//   mem_d_rdata         loaded word (meaningful with mem_d_resp on a read)
//   pmem_read/write     line fill / writeback request, held until pmem_resp
//   pmem_address        line address (offset bits zero)
//   pmem_wdata          victim line for writeback
//   pmem_rdata          fill line, valid with pmem_resp
//   pmem_resp           one-cycle pmem completion
module dcache_responder #(
    parameter int s_index  = 3,
    parameter int s_offset = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_d_read,
    input  logic         mem_d_write,
    input  logic [31:0]  mem_d_address,
    input  logic [31:0]  mem_d_wdata,
    input  logic [3:0]   mem_d_byte_enable,
    output logic         mem_d_resp,
    output logic [31:0]  mem_d_rdata,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);

    localparam int num_sets = 1 << s_index;
    localparam int tag_w    = 32 - s_index - s_offset;
    localparam int word_w   = s_offset - 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic               valid_arr [num_sets];
    logic               dirty_arr [num_sets];
    logic [tag_w-1:0]   tag_arr   [num_sets];
    logic [255:0]       data_arr  [num_sets];

    // Tag/index of the miss being serviced, captured when the miss is detected
    // so a withdrawn or changing request cannot redirect an in-flight miss.
    logic [tag_w-1:0]   miss_tag;
    logic [s_index-1:0] miss_idx;

    logic               req;
    logic [tag_w-1:0]   req_tag;
    logic [s_index-1:0] req_idx;
    logic [word_w-1:0]  req_word;
    logic               hit;
    logic [31:0]        cur_word;
    logic [31:0]        merged_word;
    logic               unused_addr_lsbs;

    assign req      = mem_d_read | mem_d_write;
    assign req_tag  = mem_d_address[31 -: tag_w];
    assign req_idx  = mem_d_address[s_offset +: s_index];
    assign req_word = mem_d_address[s_offset-1:2];
    assign hit      = valid_arr[req_idx] && (tag_arr[req_idx] == req_tag);
    assign cur_word = data_arr[req_idx][{req_word, 5'b0} +: 32];

    // Word addresses are always aligned; the byte bits carry no information.
    assign unused_addr_lsbs = ^mem_d_address[1:0];

    // Store merge: enabled lanes take new data, others keep the cached bytes.
    always_comb begin
        merged_word = cur_word;
        for (int b = 0; b < 4; b++) begin
            if (mem_d_byte_enable[b]) begin
                merged_word[b*8 +: 8] = mem_d_wdata[b*8 +: 8];
            end
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req && !hit) begin
                    if (valid_arr[req_idx] && dirty_arr[req_idx]) begin
                        next_state = WRITEBACK;
                    end else begin
                        next_state = FILL;
                    end
                end
            end
            WRITEBACK: begin
                if (pmem_resp) begin
                    next_state = FILL;
                end
            end
            FILL: begin
                if (pmem_resp) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        mem_d_resp   = 1'b0;
        mem_d_rdata  = 32'd0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 32'd0;
        pmem_wdata   = 256'd0;
        case (state)
            IDLE: begin
                mem_d_resp = req && hit;
                if (mem_d_read) begin
                    mem_d_rdata = cur_word;
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_arr[miss_idx], miss_idx, {s_offset{1'b0}}};
                pmem_wdata   = data_arr[miss_idx];
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {miss_tag, miss_idx, {s_offset{1'b0}}};
            end
            default: ;
        endcase
    end

    // ---------------- miss capture ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            miss_tag <= '0;
            miss_idx <= '0;
        end else if (state == IDLE && req && !hit) begin
            miss_tag <= req_tag;
            miss_idx <= req_idx;
        end
    end

    // ---------------- line storage ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < num_sets; i++) begin
                valid_arr[i] <= 1'b0;
                dirty_arr[i] <= 1'b0;
                tag_arr[i]   <= '0;
                data_arr[i]  <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    // A zero byte-enable store still marks the line dirty.
                    if (mem_d_write && hit) begin
                        data_arr[req_idx][{req_word, 5'b0} +: 32] <= merged_word;
                        dirty_arr[req_idx] <= 1'b1;
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) begin
                        dirty_arr[miss_idx] <= 1'b0;
                    end
                end
                FILL: begin
                    if (pmem_resp) begin
                        data_arr[miss_idx]  <= pmem_rdata;
                        tag_arr[miss_idx]   <= miss_tag;
                        valid_arr[miss_idx] <= 1'b1;
                        dirty_arr[miss_idx] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/dcache_responder.md
# dcache_responder

Direct-mapped, write-back, write-allocate data cache that serves as the responder on the core's data-memory port. It accepts single-word load/store requests from the load/store reservation station, answers hits with no wait states, and resolves misses through a 256-bit line-granular physical-memory port. It sits between the out-of-order core's LD/ST unit and the shared memory arbiter/pmem.

## Interface
Parameters:
- s_index, 3: set-index bits; number of sets = 2**s_index.
- s_offset, 5: line-offset bits; line = 32 bytes = 8 words. Fixed by the 256-bit pmem width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset rst, synchronous, active-high.
- mem_d_read  in  1  CPU load request; held high until mem_d_resp.
- mem_d_write  in  1  CPU store request; held high until mem_d_resp; never asserted together with mem_d_read.
- mem_d_address  in  32  word address; bits [1:0] are zero.
- mem_d_wdata  in  32  store data, already lane-aligned.
- mem_d_byte_enable  in  4  store byte lanes; ignored for loads.
- mem_d_resp  out  1  one-cycle completion pulse.
- mem_d_rdata  out  32  full word at mem_d_address; valid when mem_d_resp and read.
- pmem_read  out  1  line fill request; held until pmem_resp.
- pmem_write  out  1  line writeback request; held until pmem_resp.
- pmem_address  out  32  line address, bits [4:0] zero.
- pmem_wdata  out  256  victim line.
- pmem_rdata  in  256  fill line; valid with pmem_resp.
- pmem_resp  in  1  one-cycle pmem completion.

## Operation
- Address split: tag = addr[31:s_index+s_offset] (24 bits default), index = addr[s_index+s_offset-1:s_offset], word = addr[4:2].
- Per set: valid, dirty, tag, 256-bit data, all flops.
- FSM states: IDLE, WRITEBACK, FILL.
- IDLE: no request -> stay, all outputs 0. Request and hit (valid and tag match) -> mem_d_resp=1 combinationally this cycle; read: mem_d_rdata = data[index][word*32 +: 32]; write: at edge, bytes with byte_enable=1 overwrite the selected word, dirty<=1. Stay IDLE.
- IDLE, request, miss, victim valid and dirty -> WRITEBACK. Miss with victim invalid or clean -> FILL. mem_d_resp=0.
- WRITEBACK: pmem_write=1, pmem_address={victim tag, index, 5'b0}, pmem_wdata=victim line. On pmem_resp -> FILL, dirty<=0.
- FILL: pmem_read=1, pmem_address={req tag, index, 5'b0}. On pmem_resp: data<=pmem_rdata, tag<=req tag, valid<=1, dirty<=0; -> IDLE, where the still-held request hits next cycle.
- Request inputs are sampled live each cycle; initiator must hold address/data/enables stable until resp. If a request drops mid-miss, the fill/writeback still completes and the line is installed; no resp is generated.
- Store with byte_enable=4'b0000 on hit: resp issued, data unchanged, dirty still set.

## Timing
- Reset: state=IDLE; all valid and dirty=0; tags and data=0; mem_d_resp, pmem_read, pmem_write=0; pmem_address=0; mem_d_rdata, pmem_wdata=0 (derived from zeroed arrays).
- Hit latency: resp in the first cycle the request is seen (0 wait states). Back-to-back hits: one per cycle.
- Clean miss: FILL entered next cycle; resp = 1 cycle after pmem_resp cycle (IDLE re-check). Total = 1 + pmem latency + 1.
- Dirty miss: adds WRITEBACK phase before FILL.
- pmem_read/pmem_write are Moore outputs of state; deassert the cycle after pmem_resp.
- Reset mid-WRITEBACK/FILL: next cycle IDLE, pmem requests low, all lines invalid; in-flight pmem_resp ignored.
- Same-set conflict (miss evicting line that was just written): writeback carries the updated bytes.

## Test plan
- Cold read 0x0000_0104: WRITEBACK skipped, pmem_read with pmem_address 0x0000_0100; return line word1=0xDEAD_BEEF -> mem_d_resp one cycle after pmem_resp, rdata 0xDEAD_BEEF.
- Write hit 0x0000_0104, wdata 0x1122_3344, byte_enable 4'b0101 -> resp same cycle; subsequent read returns 0xDE22_BE44.
- Dirty eviction: read 0x0000_0404 (same index 0, tag differs) -> pmem_write to 0x0000_0100 with word1=0xDE22_BE44, then pmem_read 0x0000_0400, then resp.
- Hit streak: four reads to one resident line on consecutive cycles -> four consecutive resp pulses, correct words.
- Reset asserted during FILL with pmem_resp arriving next cycle -> IDLE, pmem_read=0, re-read of same address misses again.
- Request dropped mid-FILL -> no mem_d_resp; line installed; later read to it hits with zero wait states.
